// File: rtl/mem_arbiter_if.sv
// Bundle of both requester ports and the downstream SRAM controller port.
// slave is the arbiter's view; master is the view of everything around it.
interface mem_arbiter_if;
    localparam int unsigned DW = 32;

    logic          a_rd_en;
    logic          a_wr_en;
    logic [DW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic [DW-1:0] a_rdata;
    logic          a_freeze;

    logic          b_rd_en;
    logic          b_wr_en;
    logic [DW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic [DW-1:0] b_rdata;
    logic          b_freeze;

    logic          m_rd_en;
    logic          m_wr_en;
    logic [DW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ready;

    modport slave (
        input  a_rd_en, a_wr_en, a_addr, a_wdata,
        output a_rdata, a_freeze,
        input  b_rd_en, b_wr_en, b_addr, b_wdata,
        output b_rdata, b_freeze,
        output m_rd_en, m_wr_en, m_addr, m_wdata,
        input  m_rdata, m_ready
    );

    modport master (
        output a_rd_en, a_wr_en, a_addr, a_wdata,
        input  a_rdata, a_freeze,
        output b_rd_en, b_wr_en, b_addr, b_wdata,
        input  b_rdata, b_freeze,
        input  m_rd_en, m_wr_en, m_addr, m_wdata,
        output m_rdata, m_ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: serializes instruction fetch (A) and MEM stage (B)
// onto one SRAM controller, rebasing addresses and stalling the requester not served.
module mem_arbiter #(
    parameter logic [31:0] BASE_ADDR  = 32'd1024,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int unsigned DW = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          grant_b;
    logic          last_b;
    logic          req_a;
    logic          req_b;
    logic          pick_b;
    logic          sel_rd;
    logic          sel_wr;
    logic [DW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    assign req_a = bus.a_rd_en | bus.a_wr_en;
    assign req_b = bus.b_rd_en | bus.b_wr_en;

    // Stall every requester except the one completing this cycle.
    assign bus.a_freeze = req_a & ~((state == RESP) & ~grant_b);
    assign bus.b_freeze = req_b & ~((state == RESP) &  grant_b);

    // Winner selection; in round-robin a tie goes to whoever was not granted last.
    always_comb begin
        pick_b = 1'b0;
        if (FIXED_PRIO != 0) begin
            pick_b = ~req_a;
        end else begin
            pick_b = req_b & (~req_a | ~last_b);
        end
    end

    // Command of the winning port; a simultaneous read and write counts as a write.
    always_comb begin
        sel_wr    = pick_b ? bus.b_wr_en : bus.a_wr_en;
        sel_rd    = (pick_b ? bus.b_rd_en : bus.a_rd_en) & ~sel_wr;
        sel_addr  = (pick_b ? bus.b_addr : bus.a_addr) - BASE_ADDR;
        sel_wdata = pick_b ? bus.b_wdata : bus.a_wdata;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_a | req_b) state_nxt = BUSY;
            BUSY:    if (bus.m_ready)   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Downstream command registers, grant bookkeeping and read-data capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_b     <= 1'b0;
            last_b      <= 1'b1;
            bus.m_rd_en <= 1'b0;
            bus.m_wr_en <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            bus.a_rdata <= '0;
            bus.b_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_a | req_b) begin
                        grant_b     <= pick_b;
                        bus.m_rd_en <= sel_rd;
                        bus.m_wr_en <= sel_wr;
                        bus.m_addr  <= sel_addr;
                        bus.m_wdata <= sel_wdata;
                    end
                end
                BUSY: begin
                    if (bus.m_ready) begin
                        bus.m_rd_en <= 1'b0;
                        bus.m_wr_en <= 1'b0;
                        if (bus.m_rd_en) begin
                            if (grant_b) begin
                                bus.b_rdata <= bus.m_rdata;
                            end else begin
                                bus.a_rdata <= bus.m_rdata;
                            end
                        end
                    end
                end
                RESP: begin
                    last_b <= grant_b;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a
// timeline-based transaction model; a fixed-priority instance is checked separately.
module tb_mem_arbiter;
    localparam logic [31:0] BASE = 32'd1024;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_arbiter_if bus0 ();
    mem_arbiter_if bus1 ();

    mem_arbiter #(.BASE_ADDR(BASE), .FIXED_PRIO(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    mem_arbiter #(.BASE_ADDR(BASE), .FIXED_PRIO(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus0.a_rd_en = 0; bus0.a_wr_en = 0; bus0.a_addr = 0; bus0.a_wdata = 0;
        bus0.b_rd_en = 0; bus0.b_wr_en = 0; bus0.b_addr = 0; bus0.b_wdata = 0;
        bus0.m_ready = 0; bus0.m_rdata = 0;
        bus1.a_rd_en = 0; bus1.a_wr_en = 0; bus1.a_addr = 0; bus1.a_wdata = 0;
        bus1.b_rd_en = 0; bus1.b_wr_en = 0; bus1.b_addr = 0; bus1.b_wdata = 0;
        bus1.m_ready = 0; bus1.m_rdata = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b1;
    endtask

    // Act as the SRAM controller for one transaction on dut0 and report who completed.
    task automatic serve(input int lat, input logic [31:0] rd_val, output int who,
                         output logic [31:0] addr, output logic [31:0] wdata,
                         output logic rd, output logic wr);
        int  guard = 0;
        bit  seen  = 0;
        who = -1;
        while (!seen && guard < 16) begin
            next_cycle();
            guard++;
            seen = bus0.m_rd_en || bus0.m_wr_en;
        end
        chk("serve_start", 32'(seen), 32'd1);
        addr  = bus0.m_addr;
        wdata = bus0.m_wdata;
        rd    = bus0.m_rd_en;
        wr    = bus0.m_wr_en;
        for (int i = 1; i < lat; i++) begin
            next_cycle();
            chk("serve_hold_addr", bus0.m_addr, addr);
        end
        bus0.m_ready = 1'b1;
        bus0.m_rdata = rd_val;
        next_cycle();
        bus0.m_ready = 1'b0;
        bus0.m_rdata = 32'h0;
        #1;
        if (!bus0.a_freeze && (bus0.a_rd_en || bus0.a_wr_en)) who = 0;
        else if (!bus0.b_freeze && (bus0.b_rd_en || bus0.b_wr_en)) who = 1;
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return BASE + 32'($urandom_range(0, 255)) * 32'd4;
            1:       return 32'd0;
            2:       return $urandom();
            default: return BASE - 32'd4;
        endcase
    endfunction

    // Random-phase model state: requester intents and the current transaction timeline.
    logic        pend      [2];
    logic        op_rd     [2];
    logic        op_wr     [2];
    logic [31:0] r_addr    [2];
    logic [31:0] r_wdata   [2];
    logic [31:0] exp_rdata [2];
    int          grant_at, ready_at, done_at, free_at, owner, last_win, op;
    logic        t_rd, t_wr, in_win;
    logic [31:0] t_addr, t_wdata, t_rval;

    int          who;
    logic [31:0] g_addr, g_wdata;
    logic        g_rd, g_wr;
    int          rd_cnt, lo_cnt, busy, lat, a_done;
    bit          seen;

    initial begin
        // Reset values
        rst = 1'b0;
        clear_inputs();
        next_cycle();
        next_cycle();
        #1;
        chk("rst_m_rd_en",  32'(bus0.m_rd_en),  0);
        chk("rst_m_wr_en",  32'(bus0.m_wr_en),  0);
        chk("rst_m_addr",   bus0.m_addr,        0);
        chk("rst_m_wdata",  bus0.m_wdata,       0);
        chk("rst_a_rdata",  bus0.a_rdata,       0);
        chk("rst_b_rdata",  bus0.b_rdata,       0);
        chk("rst_a_freeze", 32'(bus0.a_freeze), 0);
        chk("rst_b_freeze", 32'(bus0.b_freeze), 0);
        rst = 1'b1;

        // Single B read, controller answers in the third BUSY cycle
        bus0.b_rd_en = 1'b1;
        bus0.b_addr  = 32'd1028;
        #1;
        chk("b_read_freeze_req", 32'(bus0.b_freeze), 1);
        rd_cnt = 0;
        lo_cnt = 0;
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            bus0.m_ready = (c == 3);
            bus0.m_rdata = (c == 3) ? 32'hDEADBEEF : 32'h0;
            #1;
            if (bus0.m_rd_en) rd_cnt++;
            if (!bus0.b_freeze) lo_cnt++;
            if (c == 1) chk("b_read_m_addr", bus0.m_addr, 32'd4);
        end
        chk("b_read_rd_cycles", 32'(rd_cnt), 3);
        chk("b_read_unfreeze_cycles", 32'(lo_cnt), 1);
        chk("b_read_rdata", bus0.b_rdata, 32'hDEADBEEF);
        next_cycle();
        bus0.b_rd_en = 1'b0;

        // B write to address 0 wraps below the base
        bus0.b_wr_en = 1'b1;
        bus0.b_addr  = 32'd0;
        bus0.b_wdata = 32'h12345678;
        serve(1, 32'h11111111, who, g_addr, g_wdata, g_rd, g_wr);
        chk("wrap_who",    32'(who), 1);
        chk("wrap_m_addr", g_addr, 32'hFFFFFC00);
        chk("wrap_m_wr",   32'(g_wr), 1);
        chk("wrap_m_rd",   32'(g_rd), 0);
        chk("wrap_wdata",  g_wdata, 32'h12345678);
        chk("wrap_b_rdata_kept", bus0.b_rdata, 32'hDEADBEEF);
        bus0.b_wr_en = 1'b0;

        // Read and write together on A is a write
        bus0.a_rd_en = 1'b1;
        bus0.a_wr_en = 1'b1;
        bus0.a_addr  = BASE + 32'd8;
        bus0.a_wdata = 32'h0F0F0F0F;
        serve(2, 32'h5555AAAA, who, g_addr, g_wdata, g_rd, g_wr);
        chk("rw_who",    32'(who), 0);
        chk("rw_m_wr",   32'(g_wr), 1);
        chk("rw_m_rd",   32'(g_rd), 0);
        chk("rw_m_addr", g_addr, 32'd8);
        chk("rw_a_rdata_kept", bus0.a_rdata, 32'd0);
        bus0.a_rd_en = 1'b0;
        bus0.a_wr_en = 1'b0;

        // Reset in BUSY coinciding with m_ready aborts the read
        bus0.b_rd_en = 1'b1;
        bus0.b_addr  = BASE + 32'h40;
        seen = 0;
        for (int c = 0; c < 6 && !seen; c++) begin
            next_cycle();
            seen = bus0.m_rd_en;
        end
        chk("abort_busy_seen", 32'(seen), 1);
        rst          = 1'b0;
        bus0.m_ready = 1'b1;
        bus0.m_rdata = 32'hCAFEF00D;
        next_cycle();
        bus0.m_ready = 1'b0;
        rst          = 1'b1;
        #1;
        chk("abort_m_rd_en", 32'(bus0.m_rd_en), 0);
        chk("abort_m_wr_en", 32'(bus0.m_wr_en), 0);
        chk("abort_b_rdata", bus0.b_rdata, 0);
        chk("abort_b_freeze", 32'(bus0.b_freeze), 1);
        serve(1, 32'h0BADCAFE, who, g_addr, g_wdata, g_rd, g_wr);
        chk("abort_retry_who",  32'(who), 1);
        chk("abort_retry_addr", g_addr, 32'h40);
        chk("abort_retry_rdata", bus0.b_rdata, 32'h0BADCAFE);
        bus0.b_rd_en = 1'b0;

        // Simultaneous A read / B write after reset: A first, then alternation
        do_reset();
        bus0.a_rd_en = 1'b1;
        bus0.a_addr  = BASE + 32'h10;
        bus0.b_wr_en = 1'b1;
        bus0.b_addr  = BASE + 32'h20;
        bus0.b_wdata = 32'hA5A50001;
        for (int k = 0; k < 4; k++) begin
            serve(1 + (k % 2), 32'h7000_0000 + 32'(k), who, g_addr, g_wdata, g_rd, g_wr);
            chk("alt_who", 32'(who), 32'(k % 2));
            if (k % 2 == 0) begin
                chk("alt_a_addr", g_addr, 32'h10);
                chk("alt_a_rd", 32'(g_rd), 1);
                chk("alt_a_rdata", bus0.a_rdata, 32'h7000_0000 + 32'(k));
            end else begin
                chk("alt_b_addr", g_addr, 32'h20);
                chk("alt_b_wr", 32'(g_wr), 1);
                chk("alt_b_wdata", g_wdata, 32'hA5A50001);
            end
        end

        // Randomized traffic against the transaction-timeline model
        do_reset();
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; op_rd[p] = 0; op_wr[p] = 0;
            r_addr[p] = 0; r_wdata[p] = 0; exp_rdata[p] = 0;
        end
        grant_at = -10; ready_at = -10; done_at = -10; free_at = 0;
        owner = 0; last_win = 1;
        t_rd = 0; t_wr = 0; t_addr = 0; t_wdata = 0; t_rval = 0;
        for (int n = 0; n < 1500; n++) begin
            next_cycle();
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && done_at == n - 1 && owner == p) pend[p] = 0;
                if (!pend[p]) begin
                    if ($urandom_range(0, 9) < 4) begin
                        pend[p]    = 1;
                        op         = $urandom_range(0, 2);
                        op_rd[p]   = (op != 1);
                        op_wr[p]   = (op != 0);
                        r_addr[p]  = pick_addr();
                        r_wdata[p] = $urandom();
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    r_addr[p]  = pick_addr();
                    r_wdata[p] = $urandom();
                end
            end
            bus0.a_rd_en = pend[0] & op_rd[0];
            bus0.a_wr_en = pend[0] & op_wr[0];
            bus0.a_addr  = r_addr[0];
            bus0.a_wdata = r_wdata[0];
            bus0.b_rd_en = pend[1] & op_rd[1];
            bus0.b_wr_en = pend[1] & op_wr[1];
            bus0.b_addr  = r_addr[1];
            bus0.b_wdata = r_wdata[1];

            if (n >= free_at && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) owner = (last_win == 0) ? 1 : 0;
                else                    owner = pend[1] ? 1 : 0;
                last_win = owner;
                t_wr     = op_wr[owner];
                t_rd     = op_rd[owner] & ~op_wr[owner];
                t_addr   = r_addr[owner] - BASE;
                t_wdata  = r_wdata[owner];
                t_rval   = $urandom();
                grant_at = n;
                ready_at = n + $urandom_range(1, 4);
                done_at  = ready_at + 1;
                free_at  = done_at + 1;
            end

            in_win = (n > grant_at) && (n <= ready_at);
            if (n == ready_at) begin
                bus0.m_ready = 1'b1;
                bus0.m_rdata = t_rval;
            end else if (in_win) begin
                bus0.m_ready = 1'b0;
                bus0.m_rdata = $urandom();
            end else begin
                bus0.m_ready = ($urandom_range(0, 3) == 0);
                bus0.m_rdata = $urandom();
            end
            if (n == done_at && t_rd) exp_rdata[owner] = t_rval;
            #1;
            chk("rnd_m_rd_en", 32'(bus0.m_rd_en), 32'(in_win & t_rd));
            chk("rnd_m_wr_en", 32'(bus0.m_wr_en), 32'(in_win & t_wr));
            if (in_win) begin
                chk("rnd_m_addr",  bus0.m_addr,  t_addr);
                chk("rnd_m_wdata", bus0.m_wdata, t_wdata);
            end
            chk("rnd_a_freeze", 32'(bus0.a_freeze), 32'(pend[0] && !(n == done_at && owner == 0)));
            chk("rnd_b_freeze", 32'(bus0.b_freeze), 32'(pend[1] && !(n == done_at && owner == 1)));
            chk("rnd_a_rdata", bus0.a_rdata, exp_rdata[0]);
            chk("rnd_b_rdata", bus0.b_rdata, exp_rdata[1]);
        end

        // Fixed priority: A wins every transaction while both keep requesting
        do_reset();
        bus1.a_rd_en = 1'b1;
        bus1.a_addr  = BASE + 32'h100;
        bus1.b_wr_en = 1'b1;
        bus1.b_addr  = BASE + 32'h200;
        bus1.b_wdata = 32'hB0B0B0B0;
        busy   = 0;
        lat    = 2;
        a_done = 0;
        for (int c = 0; c < 150; c++) begin
            next_cycle();
            bus1.m_ready = 1'b0;
            if (bus1.m_rd_en || bus1.m_wr_en) begin
                chk("fp_m_addr", bus1.m_addr, 32'h100);
                busy++;
                if (busy == lat) begin
                    bus1.m_ready = 1'b1;
                    bus1.m_rdata = 32'(c);
                    busy = 0;
                    lat  = $urandom_range(1, 3);
                end
            end
            #1;
            chk("fp_b_freeze", 32'(bus1.b_freeze), 1);
            if (!bus1.a_freeze) a_done++;
        end
        chk("fp_a_grants", 32'(a_done >= 20), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
